ahb_master_bridge: RTL

AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

---
 rtl/ahb_master_bridge.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_master_bridge.sv
// ---------------------------------------------------------------------------
// ahb_master_bridge
//
// Purpose:
//   Bridges a simple CPU request port onto a pipelined address/data bus.
//   CPU requests are buffered in a small FIFO and issued in acceptance order.
//   Each bus transfer has one address phase and a data phase that lasts
//   until the slave returns Ready. While a data phase is in progress, the
//   address of the next queued request is already driven, so back-to-back
//   transfers run with no idle cycle. A data phase that waits TIMEOUT cycles
//   without Ready is aborted and reported on CpuErr.
//
// Handshake:
//   The CPU side is valid/ready style. CpuReq is the valid signal and CpuAck
//   is the ready signal, and CpuAck = CpuReq & ~full. A request is
//   transferred on any rising edge where CpuAck is high. The CPU must hold
//   CpuWrite/CpuAddr/CpuWData stable while CpuReq is high and CpuAck is low.
//
// Parameters:
//   TIMEOUT  data-phase cycles without Ready before the transfer is aborted
//            (1..31, since the wait counter is 5 bits wide)
//   QDEPTH   request FIFO depth. Fixed at 2; pointer wrap relies on a
//            power-of-two depth.
//
// Ports:
//   Clk, Rst_n      clock, asynchronous active-low reset
//   CpuReq          CPU request valid
//   CpuWrite        1 = write, 0 = read
//   CpuAddr         request word address
//   CpuWData        write data
//   CpuAck          request accepted this cycle
//   CpuRValid       one-cycle pulse, CpuRData holds read data
//   CpuRData        captured read data
//   CpuErr          one-cycle pulse, oldest transfer aborted on timeout
//   CpuBusy         FIFO non-empty or bus transfer outstanding
//   Trans           bus transfer active
//   AdressBus       address-phase value
//   ReadWrite       data-phase direction
//   MasterWriteBus  data-phase write data
//   Ready           slave completed the current data phase
//   MasterReadBus   slave read data, valid with Ready
//   dbg_state_o     current FSM state (0 = IDLE, 1 = ADDR, 2 = DATA)
// ---------------------------------------------------------------------------
module ahb_master_bridge #(
  parameter int TIMEOUT = 16,
  parameter int QDEPTH  = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        CpuReq,
  input  logic        CpuWrite,
  input  logic [15:0] CpuAddr,
  input  logic [15:0] CpuWData,
  output logic        CpuAck,
  output logic        CpuRValid,
  output logic [15:0] CpuRData,
  output logic        CpuErr,
  output logic        CpuBusy,
  output logic        Trans,
  output logic [15:0] AdressBus,
  output logic        ReadWrite,
  output logic [15:0] MasterWriteBus,
  input  logic        Ready,
  input  logic [15:0] MasterReadBus,
  output logic [1:0]  dbg_state_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [4:0]       TO_VAL   = 5'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  // -------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------
  req_t             q_mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic q_empty;
  logic q_full;
  logic push;
  logic pop;
  req_t q_head;
  req_t q_in;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CNT_FULL);
  assign q_head  = q_mem_q[rd_ptr_q];
  assign q_in    = '{wr: CpuWrite, addr: CpuAddr, wdata: CpuWData};

  // Acceptance depends only on the current fill level, so a request is
  // never taken on a full FIFO even when the same edge pops an entry.
  assign CpuAck = CpuReq & ~q_full;
  assign push   = CpuAck;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge Clk) begin
    if (push) begin
      q_mem_q[wr_ptr_q] <= q_in;
    end
  end

  // -------------------------------------------------------------------------
  // Transfer FSM
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  req_t        aslot_q, aslot_d;   // request in its address phase
  req_t        dslot_q, dslot_d;   // request in its data phase
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]  wait_inc;
  logic        rvalid_q, rvalid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  assign wait_inc = wait_cnt_q + 5'd1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      aslot_q    <= '0;
      dslot_q    <= '0;
      wait_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aslot_q    <= aslot_d;
      dslot_q    <= dslot_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    aslot_d        = aslot_q;
    dslot_d        = dslot_q;
    wait_cnt_d     = wait_cnt_q;
    rvalid_d       = 1'b0;
    rdata_d        = rdata_q;
    err_d          = 1'b0;
    pop            = 1'b0;
    Trans          = 1'b0;
    AdressBus      = '0;
    ReadWrite      = 1'b0;
    MasterWriteBus = '0;

    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          aslot_d = q_head;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        Trans      = 1'b1;
        AdressBus  = aslot_q.addr;
        dslot_d    = aslot_q;
        wait_cnt_d = '0;
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        Trans          = 1'b1;
        ReadWrite      = dslot_q.wr;
        MasterWriteBus = dslot_q.wdata;
        // The next queued address is driven during this data phase, so the
        // head request has had its address phase by the time it moves
        // straight into the data slot.
        AdressBus      = q_empty ? dslot_q.addr : q_head.addr;

        if (Ready) begin
          wait_cnt_d = '0;
          if (!dslot_q.wr) begin
            rvalid_d = 1'b1;
            rdata_d  = MasterReadBus;
          end
          if (!q_empty) begin
            pop     = 1'b1;
            dslot_d = q_head;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wait_inc == TO_VAL) begin
          // Abort: the data slot is dropped and queued requests are kept.
          // Passing through IDLE leaves Trans low for exactly one cycle
          // before the next queued request starts its address phase.
          err_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign CpuRValid   = rvalid_q;
  assign CpuRData    = rdata_q;
  assign CpuErr      = err_q;
  assign CpuBusy     = ~q_empty | (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
